video_timing_gen: RTL and testbench



---
 rtl/video_pkg.sv | 23 ++
 rtl/video_axis_counter.sv | 85 ++++++++
 rtl/video_timing_gen.sv | 105 ++++++++++
 tb/tb_video_timing_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default 640x480@60 timing for the raster timing generator.
package video_pkg;

    typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Phase a given position must be in; used to cross-check the phase FSM.
    function automatic phase_t phase_at(int pos, int vis, int front, int sync);
        if (pos < vis)                    return PH_VISIBLE;
        else if (pos < vis + front)       return PH_FRONT;
        else if (pos < vis + front + sync) return PH_SYNC;
        return PH_BACK;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter plus a VISIBLE/FRONT/SYNC/BACK phase FSM
// driven by a phase-local down-counter. Next-state is exported so the top can
// register derived outputs on the same edge as the position update.
module video_axis_counter
    import video_pkg::*;
#(
    parameter int  L_VISIBLE = DEF_H_VISIBLE,
    parameter int  L_FRONT   = DEF_H_FRONT,
    parameter int  L_SYNC    = DEF_H_SYNC,
    parameter int  L_BACK    = DEF_H_BACK,
    localparam int TOTAL     = L_VISIBLE + L_FRONT + L_SYNC + L_BACK,
    localparam int PW        = $clog2(TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          step,
    output logic [PW-1:0] pos,
    output phase_t        phase,
    output phase_t        phase_nxt,
    output logic          wrap
);

    if (L_VISIBLE <= 0 || L_FRONT <= 0 || L_SYNC <= 0 || L_BACK <= 0) begin : g_bad_len
        $error("video_axis_counter: every phase length must be nonzero");
    end

    logic [PW-1:0] pos_q, pos_d;
    logic [PW-1:0] cnt_q, cnt_d;
    phase_t        phase_q, phase_d;

    function automatic logic [PW-1:0] len_m1(phase_t p);
        case (p)
            PH_VISIBLE: return PW'(L_VISIBLE - 1);
            PH_FRONT:   return PW'(L_FRONT - 1);
            PH_SYNC:    return PW'(L_SYNC - 1);
            default:    return PW'(L_BACK - 1);
        endcase
    endfunction

    function automatic phase_t next_phase(phase_t p);
        case (p)
            PH_VISIBLE: return PH_FRONT;
            PH_FRONT:   return PH_SYNC;
            PH_SYNC:    return PH_BACK;
            default:    return PH_VISIBLE;
        endcase
    endfunction

    assign wrap = (pos_q == PW'(TOTAL - 1));

    always_comb begin
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (step) begin
            pos_d = wrap ? '0 : pos_q + PW'(1);
            if (cnt_q == '0) begin
                phase_d = next_phase(phase_q);
                cnt_d   = len_m1(phase_d);
            end else begin
                cnt_d = cnt_q - PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q   <= '0;
            cnt_q   <= PW'(L_VISIBLE - 1);
            phase_q <= PH_VISIBLE;
        end else begin
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign pos       = pos_q;
    assign phase     = phase_q;
    assign phase_nxt = phase_d;

    a_phase_matches_pos: assert property (@(posedge clock) disable iff (reset)
        phase_q == phase_at(int'(pos_q), L_VISIBLE, L_FRONT, L_SYNC));

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator on the system clock, advanced by the divider's
// pixel strobe. All outputs are registered and change with col/row.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pix_en,
    output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0] col,
    output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0] row,
    output logic hsync,
    output logic vsync,
    output logic blank,
    output logic line_start,
    output logic frame_start,
    output logic vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;
    phase_t        h_phase, h_phase_nxt, v_phase, v_phase_nxt;
    logic          h_wrap, v_wrap, v_step;

    logic hsync_q, vsync_q, blank_q;
    logic line_start_q, frame_start_q, vblank_start_q;

    assign v_step = pix_en & h_wrap;

    video_axis_counter #(
        .L_VISIBLE (H_VISIBLE),
        .L_FRONT   (H_FRONT),
        .L_SYNC    (H_SYNC),
        .L_BACK    (H_BACK)
    ) u_h_axis (
        .clock     (clock),
        .reset     (reset),
        .step      (pix_en),
        .pos       (h_pos),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    video_axis_counter #(
        .L_VISIBLE (V_VISIBLE),
        .L_FRONT   (V_FRONT),
        .L_SYNC    (V_SYNC),
        .L_BACK    (V_BACK)
    ) u_v_axis (
        .clock     (clock),
        .reset     (reset),
        .step      (v_step),
        .pos       (v_pos),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    // Derived outputs use the counters' next state so they land on the same edge as col/row.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            blank_q        <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hsync_q        <= (h_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_q        <= (v_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            blank_q        <= (h_phase_nxt != PH_VISIBLE) || (v_phase_nxt != PH_VISIBLE);
            line_start_q   <= v_step;
            frame_start_q  <= v_step & v_wrap;
            vblank_start_q <= v_step & (v_pos == VW'(V_VISIBLE - 1));
        end
    end

    assign col          = h_pos;
    assign row          = v_pos;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank        = blank_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

    a_blank_matches_phase: assert property (@(posedge clock) disable iff (reset)
        blank_q == ((h_phase != PH_VISIBLE) || (v_phase != PH_VISIBLE)));

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default 640x480 instance plus a small-timing pair (both sync
// polarities) checked against a position-threshold model through scoreboards.
module tb_video_timing_gen;

    typedef struct {
        int col;
        int row;
        bit hs;
        bit vs;
        bit bl;
        bit ls;
        bit fs;
        bit vb;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // default-timing instance
    logic       pe_d = 1'b0, rst_d = 1'b1;
    logic [9:0] col_d, row_d;
    logic       hs_d, vs_d, bl_d, ls_d, fs_d, vb_d;

    // small-timing instances (H 4/1/2/1, V 2/1/1/1), active-low and active-high sync
    logic       pe_s = 1'b0, rst_s = 1'b1;
    logic [2:0] col_s, row_s, col_p, row_p;
    logic       hs_s, vs_s, bl_s, ls_s, fs_s, vb_s;
    logic       hs_p, vs_p, bl_p, ls_p, fs_p, vb_p;

    video_timing_gen dut_d (
        .clock(clock), .reset(rst_d), .pix_en(pe_d),
        .col(col_d), .row(row_d), .hsync(hs_d), .vsync(vs_d), .blank(bl_d),
        .line_start(ls_d), .frame_start(fs_d), .vblank_start(vb_d)
    );

    video_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b0)
    ) dut_s (
        .clock(clock), .reset(rst_s), .pix_en(pe_s),
        .col(col_s), .row(row_s), .hsync(hs_s), .vsync(vs_s), .blank(bl_s),
        .line_start(ls_s), .frame_start(fs_s), .vblank_start(vb_s)
    );

    video_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut_p (
        .clock(clock), .reset(rst_s), .pix_en(pe_s),
        .col(col_p), .row(row_p), .hsync(hs_p), .vsync(vs_p), .blank(bl_p),
        .line_start(ls_p), .frame_start(fs_p), .vblank_start(vb_p)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_d[$];
    exp_t sb_s[$];
    exp_t sb_p[$];
    int   dcol = 0, drow = 0, scol = 0, srow = 0;

    function automatic exp_t mk(int c, int r, int hv, int hf, int hsw, int vv, int vf, int vsw,
                                bit pol, bit ls, bit fs, bit vb);
        exp_t e;
        e.col = c;
        e.row = r;
        e.hs  = (c >= hv + hf && c < hv + hf + hsw) ? pol : ~pol;
        e.vs  = (r >= vv + vf && r < vv + vf + vsw) ? pol : ~pol;
        e.bl  = (c >= hv) || (r >= vv);
        e.ls  = ls;
        e.fs  = fs;
        e.vb  = vb;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string who, input exp_t e,
                           input logic [31:0] c, input logic [31:0] r,
                           input logic hs, input logic vs, input logic bl,
                           input logic ls, input logic fs, input logic vb);
        chk({who, ".col"},          c,       32'(e.col));
        chk({who, ".row"},          r,       32'(e.row));
        chk({who, ".hsync"},        32'(hs), 32'(e.hs));
        chk({who, ".vsync"},        32'(vs), 32'(e.vs));
        chk({who, ".blank"},        32'(bl), 32'(e.bl));
        chk({who, ".line_start"},   32'(ls), 32'(e.ls));
        chk({who, ".frame_start"},  32'(fs), 32'(e.fs));
        chk({who, ".vblank_start"}, 32'(vb), 32'(e.vb));
    endtask

    // One clock on the default instance: drive, predict, then compare half a cycle after the edge.
    task automatic d_cyc(input bit en, input bit rst);
        bit   ls = 1'b0, fs = 1'b0, vb = 1'b0;
        exp_t e;
        pe_d  = en;
        rst_d = rst;
        if (rst) begin
            dcol = 0;
            drow = 0;
        end else if (en) begin
            if (dcol == 799) begin
                dcol = 0;
                drow = (drow == 524) ? 0 : drow + 1;
                ls   = 1'b1;
                fs   = (drow == 0);
                vb   = (drow == 480);
            end else begin
                dcol++;
            end
        end
        sb_d.push_back(mk(dcol, drow, 640, 16, 96, 480, 10, 2, 1'b0, ls, fs, vb));
        @(negedge clock);
        e = sb_d.pop_front();
        chk_all("d", e, 32'(col_d), 32'(row_d), hs_d, vs_d, bl_d, ls_d, fs_d, vb_d);
    endtask

    task automatic s_cyc(input bit en, input bit rst);
        bit   ls = 1'b0, fs = 1'b0, vb = 1'b0;
        exp_t e;
        pe_s  = en;
        rst_s = rst;
        if (rst) begin
            scol = 0;
            srow = 0;
        end else if (en) begin
            if (scol == 7) begin
                scol = 0;
                srow = (srow == 4) ? 0 : srow + 1;
                ls   = 1'b1;
                fs   = (srow == 0);
                vb   = (srow == 2);
            end else begin
                scol++;
            end
        end
        sb_s.push_back(mk(scol, srow, 4, 1, 2, 2, 1, 1, 1'b0, ls, fs, vb));
        sb_p.push_back(mk(scol, srow, 4, 1, 2, 2, 1, 1, 1'b1, ls, fs, vb));
        @(negedge clock);
        e = sb_s.pop_front();
        chk_all("s", e, 32'(col_s), 32'(row_s), hs_s, vs_s, bl_s, ls_s, fs_s, vb_s);
        e = sb_p.pop_front();
        chk_all("p", e, 32'(col_p), 32'(row_p), hs_p, vs_p, bl_p, ls_p, fs_p, vb_p);
    endtask

    initial begin
        @(negedge clock);

        // default timing: reset state
        d_cyc(1'b0, 1'b1);
        d_cyc(1'b0, 1'b1);
        d_cyc(1'b0, 1'b0);

        // one full line with strobes every other cycle; ends at col 0, row 1
        for (int i = 0; i < 800; i++) begin
            d_cyc(1'b1, 1'b0);
            d_cyc(1'b0, 1'b0);
        end

        // park at col 300, hold pix_en low, then resume to 301
        for (int i = 0; i < 300; i++) d_cyc(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) d_cyc(1'b0, 1'b0);
        d_cyc(1'b1, 1'b0);

        // continue to col 700 with back-to-back strobes, then reset while pix_en is high
        for (int i = 0; i < 399; i++) d_cyc(1'b1, 1'b0);
        d_cyc(1'b1, 1'b1);
        d_cyc(1'b0, 1'b0);
        d_cyc(1'b1, 1'b0);
        pe_d = 1'b0;

        // small timing, both polarities: reset, then three frames at full rate
        s_cyc(1'b0, 1'b1);
        s_cyc(1'b0, 1'b1);
        s_cyc(1'b0, 1'b0);
        for (int i = 0; i < 120; i++) s_cyc(1'b1, 1'b0);

        // irregular strobe spacing over a couple of frames
        for (int i = 0; i < 160; i++) s_cyc(1'($urandom_range(0, 1)), 1'b0);

        // hold low mid-frame
        for (int i = 0; i < 20; i++) s_cyc(1'b0, 1'b0);

        // walk to (col 5, row 3), reset with pix_en high, then a full frame from stepping
        for (int i = 0; i < 64 && !(scol == 5 && srow == 3); i++) s_cyc(1'b1, 1'b0);
        s_cyc(1'b1, 1'b1);
        for (int i = 0; i < 41; i++) s_cyc(1'b1, 1'b0);
        s_cyc(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
